// File: rtl/multicycle_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_controller_if
//  Description : Opcode, memory handshake, hold input and control strobes
//                exchanged between the multi-cycle controller and the
//                datapath/memories.
//  Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_controller_if;
  logic [6:0] Opcode;
  logic       imem_ready;
  logic       dmem_ready;
  logic       stall;
  logic       ImemReq;
  logic       IRWrite;
  logic       PCWrite;
  logic       ALUSrc;
  logic       MemtoReg;
  logic       RegWrite;
  logic       MemRead;
  logic       MemWrite;
  logic [1:0] ALUOp;
  logic       Branch;
  logic       Jump;
  logic       Illegal;
  logic       TimeoutErr;
  logic [2:0] State;

  // Controller side
  modport slave (
    input  Opcode, imem_ready, dmem_ready, stall,
    output ImemReq, IRWrite, PCWrite, ALUSrc, MemtoReg, RegWrite,
           MemRead, MemWrite, ALUOp, Branch, Jump, Illegal, TimeoutErr, State
  );

  // Datapath / memory side
  modport master (
    output Opcode, imem_ready, dmem_ready, stall,
    input  ImemReq, IRWrite, PCWrite, ALUSrc, MemtoReg, RegWrite,
           MemRead, MemWrite, ALUOp, Branch, Jump, Illegal, TimeoutErr, State
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_controller
//  Description : RV32I multi-cycle control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP)
//                with variable-latency memory handshakes, wait timeout, stall
//                and sticky illegal-opcode / timeout trap flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller #(
  parameter int unsigned MEM_TIMEOUT  = 16,
  parameter bit          ENABLE_JUMPS = 1'b1,
  parameter int unsigned CNT_W        = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_controller_if.slave bus
);

  localparam logic [6:0] c_op_r    = 7'b0110011;
  localparam logic [6:0] c_op_i    = 7'b0010011;
  localparam logic [6:0] c_op_lw   = 7'b0000011;
  localparam logic [6:0] c_op_sw   = 7'b0100011;
  localparam logic [6:0] c_op_br   = 7'b1100011;
  localparam logic [6:0] c_op_jal  = 7'b1101111;
  localparam logic [6:0] c_op_jalr = 7'b1100111;

  // One extra bit so the incremented count never wraps before the compare
  localparam logic [CNT_W:0] c_limit = MEM_TIMEOUT[CNT_W:0];

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [6:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d;
  logic             timeout_q, timeout_d;

  logic             w_legal;
  logic [CNT_W:0]   w_cnt_inc;
  logic             w_limit_hit;
  logic             w_is_lw, w_is_sw, w_is_br, w_is_i, w_is_jal, w_is_jalr;

  assign w_is_lw   = (op_q == c_op_lw);
  assign w_is_sw   = (op_q == c_op_sw);
  assign w_is_br   = (op_q == c_op_br);
  assign w_is_i    = (op_q == c_op_i);
  assign w_is_jal  = (op_q == c_op_jal);
  assign w_is_jalr = (op_q == c_op_jalr);

  assign w_cnt_inc   = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  assign w_limit_hit = (MEM_TIMEOUT != 0) && (w_cnt_inc == c_limit);

  assign bus.State      = state_q;
  assign bus.Illegal    = illegal_q;
  assign bus.TimeoutErr = timeout_q;

  // Opcode legality check applied to the live IR field during DECODE
  always_comb begin
    w_legal = (bus.Opcode == c_op_r)  || (bus.Opcode == c_op_i)  ||
              (bus.Opcode == c_op_lw) || (bus.Opcode == c_op_sw) ||
              (bus.Opcode == c_op_br);
    if (ENABLE_JUMPS && ((bus.Opcode == c_op_jal) || (bus.Opcode == c_op_jalr)))
      w_legal = 1'b1;
  end

  // Next-state, counter, flag and strobe generation; stall freezes all state
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    cnt_d         = cnt_q;
    illegal_d     = illegal_q;
    timeout_d     = timeout_q;
    bus.ImemReq   = 1'b0;
    bus.IRWrite   = 1'b0;
    bus.PCWrite   = 1'b0;
    bus.ALUSrc    = 1'b0;
    bus.MemtoReg  = 1'b0;
    bus.RegWrite  = 1'b0;
    bus.MemRead   = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.ALUOp     = 2'b00;
    bus.Branch    = 1'b0;
    bus.Jump      = 1'b0;

    unique case (state_q)
      FETCH: begin
        bus.ImemReq = 1'b1;
        if (!bus.stall) begin
          if (bus.imem_ready) begin
            // Gated by reset so the Mealy strobes cannot pulse while held in reset
            bus.IRWrite = reset;
            bus.PCWrite = reset;
            state_d     = DECODE;
          end else if (w_limit_hit) begin
            state_d   = TRAP;
            timeout_d = 1'b1;
          end else begin
            cnt_d = w_cnt_inc[CNT_W-1:0];
          end
        end
      end
      DECODE: begin
        if (!bus.stall) begin
          op_d = bus.Opcode;
          if (w_legal) begin
            state_d = EXEC;
          end else begin
            state_d   = TRAP;
            illegal_d = 1'b1;
          end
        end
      end
      EXEC: begin
        bus.ALUSrc = w_is_lw || w_is_sw || w_is_i || w_is_jalr;
        bus.Branch = w_is_br;
        bus.Jump   = w_is_jal || w_is_jalr;
        if (w_is_lw || w_is_sw)        bus.ALUOp = 2'b00;
        else if (w_is_br)              bus.ALUOp = 2'b01;
        else if (w_is_jal || w_is_jalr) bus.ALUOp = 2'b11;
        else                           bus.ALUOp = 2'b10;
        if (!bus.stall) begin
          if (w_is_br)                 state_d = FETCH;
          else if (w_is_lw || w_is_sw) state_d = MEM;
          else                         state_d = WB;
        end
      end
      MEM: begin
        bus.MemRead  = w_is_lw;
        bus.MemWrite = w_is_sw && !bus.stall;
        if (!bus.stall) begin
          if (bus.dmem_ready) begin
            state_d = w_is_lw ? WB : FETCH;
          end else if (w_limit_hit) begin
            state_d   = TRAP;
            timeout_d = 1'b1;
          end else begin
            cnt_d = w_cnt_inc[CNT_W-1:0];
          end
        end
      end
      WB: begin
        bus.RegWrite = !bus.stall;
        bus.MemtoReg = w_is_lw;
        if (!bus.stall) state_d = FETCH;
      end
      TRAP: begin
        state_d = TRAP;
      end
      default: begin
        state_d = FETCH;
      end
    endcase

    // Each wait phase starts counting from zero
    if ((state_d != state_q) && ((state_d == FETCH) || (state_d == MEM)))
      cnt_d = '0;
  end

  // State and sticky-flag registers, asynchronously cleared
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= FETCH;
      op_q      <= 7'd0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_controller
//  Description : Scoreboard bench for multicycle_controller. Three instances
//                (default, MEM_TIMEOUT=4, ENABLE_JUMPS=0) share one stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

  localparam logic [6:0] c_op_r    = 7'b0110011;
  localparam logic [6:0] c_op_i    = 7'b0010011;
  localparam logic [6:0] c_op_lw   = 7'b0000011;
  localparam logic [6:0] c_op_sw   = 7'b0100011;
  localparam logic [6:0] c_op_br   = 7'b1100011;
  localparam logic [6:0] c_op_jal  = 7'b1101111;
  localparam logic [6:0] c_op_jalr = 7'b1100111;
  localparam logic [6:0] c_op_bad  = 7'b1111111;

  // Expected strobe bits
  localparam logic [13:0] c_imr    = 14'h2000;
  localparam logic [13:0] c_irw    = 14'h1000;
  localparam logic [13:0] c_pcw    = 14'h0800;
  localparam logic [13:0] c_asrc   = 14'h0400;
  localparam logic [13:0] c_m2r    = 14'h0200;
  localparam logic [13:0] c_rw     = 14'h0100;
  localparam logic [13:0] c_mr     = 14'h0080;
  localparam logic [13:0] c_mw     = 14'h0040;
  localparam logic [13:0] c_aop_br = 14'h0010;
  localparam logic [13:0] c_aop_ri = 14'h0020;
  localparam logic [13:0] c_aop_j  = 14'h0030;
  localparam logic [13:0] c_br     = 14'h0008;
  localparam logic [13:0] c_jmp    = 14'h0004;
  localparam logic [13:0] c_ill    = 14'h0002;
  localparam logic [13:0] c_to     = 14'h0001;
  localparam logic [13:0] c_none   = 14'h0000;
  localparam logic [13:0] c_frdy   = c_imr | c_irw | c_pcw;

  // Input bundles {imem_ready, dmem_ready, stall}
  localparam logic [2:0] c_in_0  = 3'b000;
  localparam logic [2:0] c_in_ir = 3'b100;
  localparam logic [2:0] c_in_dr = 3'b010;
  localparam logic [2:0] c_in_st = 3'b001;

  localparam logic [2:0] s_f = 3'd0, s_d = 3'd1, s_e = 3'd2, s_m = 3'd3, s_w = 3'd4, s_t = 3'd5;

  logic clk;
  logic reset;

  multicycle_controller_if if_a ();
  multicycle_controller_if if_t ();
  multicycle_controller_if if_j ();

  multicycle_controller #(.MEM_TIMEOUT(16), .ENABLE_JUMPS(1'b1), .CNT_W(5)) dut_a (
    .clk(clk), .reset(reset), .bus(if_a.slave));
  multicycle_controller #(.MEM_TIMEOUT(4), .ENABLE_JUMPS(1'b1), .CNT_W(3)) dut_t (
    .clk(clk), .reset(reset), .bus(if_t.slave));
  multicycle_controller #(.MEM_TIMEOUT(16), .ENABLE_JUMPS(1'b0), .CNT_W(5)) dut_j (
    .clk(clk), .reset(reset), .bus(if_j.slave));

  logic [16:0] w_snap_a, w_snap_t, w_snap_j;
  assign w_snap_a = {if_a.State, if_a.ImemReq, if_a.IRWrite, if_a.PCWrite, if_a.ALUSrc,
                     if_a.MemtoReg, if_a.RegWrite, if_a.MemRead, if_a.MemWrite, if_a.ALUOp,
                     if_a.Branch, if_a.Jump, if_a.Illegal, if_a.TimeoutErr};
  assign w_snap_t = {if_t.State, if_t.ImemReq, if_t.IRWrite, if_t.PCWrite, if_t.ALUSrc,
                     if_t.MemtoReg, if_t.RegWrite, if_t.MemRead, if_t.MemWrite, if_t.ALUOp,
                     if_t.Branch, if_t.Jump, if_t.Illegal, if_t.TimeoutErr};
  assign w_snap_j = {if_j.State, if_j.ImemReq, if_j.IRWrite, if_j.PCWrite, if_j.ALUSrc,
                     if_j.MemtoReg, if_j.RegWrite, if_j.MemRead, if_j.MemWrite, if_j.ALUOp,
                     if_j.Branch, if_j.Jump, if_j.Illegal, if_j.TimeoutErr};

  typedef struct {
    int          sel;
    bit          pre_rst;
    logic [6:0]  op;
    logic [2:0]  in;
    logic [16:0] exp;
  } row_t;

  row_t        rows[$];
  logic [16:0] sb[$];
  int          vectors     = 0;
  int          miscompares = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [16:0] snap(input int sel);
    case (sel)
      0:       return w_snap_a;
      1:       return w_snap_t;
      default: return w_snap_j;
    endcase
  endfunction

  task automatic add(input int sel, input bit pre, input logic [6:0] op,
                     input logic [2:0] in, input logic [2:0] s, input logic [13:0] v);
    row_t r;
    r.sel = sel; r.pre_rst = pre; r.op = op; r.in = in; r.exp = {s, v};
    rows.push_back(r);
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] in);
    if_a.Opcode = op; if_a.imem_ready = in[2]; if_a.dmem_ready = in[1]; if_a.stall = in[0];
    if_t.Opcode = op; if_t.imem_ready = in[2]; if_t.dmem_ready = in[1]; if_t.stall = in[0];
    if_j.Opcode = op; if_j.imem_ready = in[2]; if_j.dmem_ready = in[1]; if_j.stall = in[0];
  endtask

  task automatic do_reset();
    drive(7'd0, c_in_0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [16:0] got;
    drive(7'd0, c_in_ir);
    reset = 1'b0;
    #2;
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < 3; s++) begin
        got = snap(s);
        vectors++;
        if (got !== {s_f, c_imr}) begin
          miscompares++;
          $display("FAIL reset pass%0d dut%0d: got %b, want %b", k, s, got, {s_f, c_imr});
        end
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_rtype();
    logic [16:0] got, want;
    add(0, 1'b1, c_op_r, c_in_ir, s_f, c_frdy);
    add(0, 1'b0, c_op_r, c_in_ir, s_d, c_none);
    add(0, 1'b0, c_op_r, c_in_ir, s_e, c_aop_ri);
    add(0, 1'b0, c_op_r, c_in_0,  s_w, c_rw);
    add(0, 1'b0, c_op_r, c_in_0,  s_f, c_imr);
    foreach (rows[i]) begin
      if (rows[i].pre_rst) do_reset();
      drive(rows[i].op, rows[i].in);
      sb.push_back(rows[i].exp);
      @(negedge clk);
      got = snap(rows[i].sel); want = sb.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL rtype[%0d]: got st=%0d v=%b, want st=%0d v=%b", i, got[16:14], got[13:0], want[16:14], want[13:0]);
      end
      @(posedge clk); #1;
    end
    rows.delete();
  endtask

  task automatic test_lw_wait();
    logic [16:0] got, want;
    add(0, 1'b1, c_op_lw, c_in_ir, s_f, c_frdy);
    add(0, 1'b0, c_op_lw, c_in_0,  s_d, c_none);
    add(0, 1'b0, c_op_lw, c_in_0,  s_e, c_asrc);
    add(0, 1'b0, c_op_lw, c_in_0,  s_m, c_mr);
    add(0, 1'b0, c_op_lw, c_in_0,  s_m, c_mr);
    add(0, 1'b0, c_op_lw, c_in_0,  s_m, c_mr);
    add(0, 1'b0, c_op_lw, c_in_dr, s_m, c_mr);
    add(0, 1'b0, c_op_lw, c_in_0,  s_w, c_rw | c_m2r);
    add(0, 1'b0, c_op_lw, c_in_0,  s_f, c_imr);
    foreach (rows[i]) begin
      if (rows[i].pre_rst) do_reset();
      drive(rows[i].op, rows[i].in);
      sb.push_back(rows[i].exp);
      @(negedge clk);
      got = snap(rows[i].sel); want = sb.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL lw_wait[%0d]: got st=%0d v=%b, want st=%0d v=%b", i, got[16:14], got[13:0], want[16:14], want[13:0]);
      end
      @(posedge clk); #1;
    end
    rows.delete();
  endtask

  task automatic test_sw_stall();
    logic [16:0] got, want;
    add(0, 1'b1, c_op_sw, c_in_ir,           s_f, c_frdy);
    add(0, 1'b0, c_op_sw, c_in_0,            s_d, c_none);
    add(0, 1'b0, c_op_sw, c_in_0,            s_e, c_asrc);
    add(0, 1'b0, c_op_sw, c_in_0,            s_m, c_mw);
    add(0, 1'b0, c_op_sw, c_in_st | c_in_dr, s_m, c_none);
    add(0, 1'b0, c_op_sw, c_in_st,           s_m, c_none);
    add(0, 1'b0, c_op_sw, c_in_dr,           s_m, c_mw);
    add(0, 1'b0, c_op_sw, c_in_0,            s_f, c_imr);
    foreach (rows[i]) begin
      if (rows[i].pre_rst) do_reset();
      drive(rows[i].op, rows[i].in);
      sb.push_back(rows[i].exp);
      @(negedge clk);
      got = snap(rows[i].sel); want = sb.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL sw_stall[%0d]: got st=%0d v=%b, want st=%0d v=%b", i, got[16:14], got[13:0], want[16:14], want[13:0]);
      end
      @(posedge clk); #1;
    end
    rows.delete();
  endtask

  task automatic test_illegal();
    logic [16:0] got, want;
    add(0, 1'b1, c_op_bad, c_in_ir, s_f, c_frdy);
    add(0, 1'b0, c_op_bad, c_in_0,  s_d, c_none);
    for (int k = 0; k < 10; k++)
      add(0, 1'b0, c_op_bad, c_in_ir | c_in_dr, s_t, c_ill);
    foreach (rows[i]) begin
      if (rows[i].pre_rst) do_reset();
      drive(rows[i].op, rows[i].in);
      sb.push_back(rows[i].exp);
      @(negedge clk);
      got = snap(rows[i].sel); want = sb.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL illegal[%0d]: got st=%0d v=%b, want st=%0d v=%b", i, got[16:14], got[13:0], want[16:14], want[13:0]);
      end
      @(posedge clk); #1;
    end
    rows.delete();
    // Asynchronous reset taken mid-cycle while trapped
    drive(7'd0, c_in_0);
    #2;
    reset = 1'b0;
    #1;
    got = w_snap_a; vectors++;
    if (got !== {s_f, c_imr}) begin
      miscompares++;
      $display("FAIL illegal_async_reset: got %b, want %b", got, {s_f, c_imr});
    end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    logic [16:0] got, want;
    // FETCH wait with no ready: trap after four wait cycles
    add(1, 1'b1, c_op_r, c_in_0, s_f, c_imr);
    add(1, 1'b0, c_op_r, c_in_0, s_f, c_imr);
    add(1, 1'b0, c_op_r, c_in_0, s_f, c_imr);
    add(1, 1'b0, c_op_r, c_in_0, s_f, c_imr);
    add(1, 1'b0, c_op_r, c_in_0, s_t, c_to);
    // Ready on the cycle the limit is reached wins
    add(1, 1'b1, c_op_r, c_in_0,  s_f, c_imr);
    add(1, 1'b0, c_op_r, c_in_0,  s_f, c_imr);
    add(1, 1'b0, c_op_r, c_in_0,  s_f, c_imr);
    add(1, 1'b0, c_op_r, c_in_ir, s_f, c_frdy);
    add(1, 1'b0, c_op_r, c_in_0,  s_d, c_none);
    add(1, 1'b0, c_op_r, c_in_0,  s_e, c_aop_ri);
    // Data-side wait without dmem_ready
    add(1, 1'b1, c_op_lw, c_in_ir, s_f, c_frdy);
    add(1, 1'b0, c_op_lw, c_in_0,  s_d, c_none);
    add(1, 1'b0, c_op_lw, c_in_0,  s_e, c_asrc);
    for (int k = 0; k < 4; k++)
      add(1, 1'b0, c_op_lw, c_in_0, s_m, c_mr);
    add(1, 1'b0, c_op_lw, c_in_0, s_t, c_to);
    foreach (rows[i]) begin
      if (rows[i].pre_rst) do_reset();
      drive(rows[i].op, rows[i].in);
      sb.push_back(rows[i].exp);
      @(negedge clk);
      got = snap(rows[i].sel); want = sb.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL timeout[%0d]: got st=%0d v=%b, want st=%0d v=%b", i, got[16:14], got[13:0], want[16:14], want[13:0]);
      end
      @(posedge clk); #1;
    end
    rows.delete();
  endtask

  task automatic test_jumps();
    logic [16:0] got, want;
    add(0, 1'b1, c_op_jal,  c_in_ir, s_f, c_frdy);
    add(0, 1'b0, c_op_jal,  c_in_0,  s_d, c_none);
    add(0, 1'b0, c_op_jal,  c_in_0,  s_e, c_aop_j | c_jmp);
    add(0, 1'b0, c_op_jal,  c_in_ir, s_w, c_rw);
    add(0, 1'b0, c_op_jalr, c_in_ir, s_f, c_frdy);
    add(0, 1'b0, c_op_jalr, c_in_0,  s_d, c_none);
    add(0, 1'b0, c_op_jalr, c_in_0,  s_e, c_aop_j | c_jmp | c_asrc);
    add(0, 1'b0, c_op_jalr, c_in_0,  s_w, c_rw);
    add(2, 1'b1, c_op_jal,  c_in_ir, s_f, c_frdy);
    add(2, 1'b0, c_op_jal,  c_in_0,  s_d, c_none);
    add(2, 1'b0, c_op_jal,  c_in_ir, s_t, c_ill);
    foreach (rows[i]) begin
      if (rows[i].pre_rst) do_reset();
      drive(rows[i].op, rows[i].in);
      sb.push_back(rows[i].exp);
      @(negedge clk);
      got = snap(rows[i].sel); want = sb.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL jumps[%0d]: got st=%0d v=%b, want st=%0d v=%b", i, got[16:14], got[13:0], want[16:14], want[13:0]);
      end
      @(posedge clk); #1;
    end
    rows.delete();
  endtask

  task automatic test_back_to_back();
    logic [16:0] got, want;
    add(0, 1'b1, c_op_br,  c_in_ir | c_in_st, s_f, c_imr);
    add(0, 1'b0, c_op_br,  c_in_ir,           s_f, c_frdy);
    add(0, 1'b0, c_op_br,  c_in_0,            s_d, c_none);
    add(0, 1'b0, c_op_br,  c_in_0,            s_e, c_aop_br | c_br);
    add(0, 1'b0, c_op_i,   c_in_ir,           s_f, c_frdy);
    add(0, 1'b0, c_op_bad, c_in_st,           s_d, c_none);
    add(0, 1'b0, c_op_i,   c_in_0,            s_d, c_none);
    add(0, 1'b0, c_op_i,   c_in_0,            s_e, c_asrc | c_aop_ri);
    add(0, 1'b0, c_op_i,   c_in_st,           s_w, c_none);
    add(0, 1'b0, c_op_i,   c_in_0,            s_w, c_rw);
    add(0, 1'b0, c_op_i,   c_in_0,            s_f, c_imr);
    foreach (rows[i]) begin
      if (rows[i].pre_rst) do_reset();
      drive(rows[i].op, rows[i].in);
      sb.push_back(rows[i].exp);
      @(negedge clk);
      got = snap(rows[i].sel); want = sb.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL back_to_back[%0d]: got st=%0d v=%b, want st=%0d v=%b", i, got[16:14], got[13:0], want[16:14], want[13:0]);
      end
      @(posedge clk); #1;
    end
    rows.delete();
  endtask

  initial begin
    reset = 1'b0;
    drive(7'd0, c_in_0);
    test_reset();
    test_rtype();
    test_lw_wait();
    test_sw_stall();
    test_illegal();
    test_timeout();
    test_jumps();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Multi-cycle successor to the single-cycle main decoder. An FSM sequences each RV32I instruction through FETCH/DECODE/EXEC/MEM/WB. It handshakes with instruction and data memory that have variable latency, and traps on illegal opcodes or memory timeouts. It sits between the IR/PC registers and the datapath and drives the same control strobes, each qualified per state.

Parameters:
MEM_TIMEOUT, 16, max wait cycles for imem_ready/dmem_ready before trap; 0 disables the timeout
ENABLE_JUMPS, 1, 1: JAL/JALR legal; 0: JAL/JALR decode as illegal
CNT_W, 5, timeout counter width; must satisfy 2**CNT_W > MEM_TIMEOUT

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low
Opcode  in  7  IR[6:0]; valid from DECODE onward
imem_ready  in  1  instruction word valid this cycle
dmem_ready  in  1  data access completes this cycle
stall  in  1  external hold
ImemReq  out  1  instruction fetch request
IRWrite  out  1  load IR
PCWrite  out  1  load PC+4
ALUSrc  out  1  0: rs2; 1: immediate
MemtoReg  out  1  1: write-back data from memory
RegWrite  out  1  register file write strobe
MemRead  out  1  data memory read request
MemWrite  out  1  data memory write request
ALUOp  out  2  00 ld/st; 01 branch; 10 R/I; 11 jump link
Branch  out  1  conditional branch; datapath qualifies with Zero
Jump  out  1  unconditional PC redirect
Illegal  out  1  sticky illegal-opcode flag
TimeoutErr  out  1  sticky memory-timeout flag
State  out  3  current state, for debug

Behaviour:
- Legal opcodes:
  - R 0110011, I 0010011, LW 0000011, SW 0100011, BR 1100011.
  - JAL 1101111 and JALR 1100111 when ENABLE_JUMPS=1.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- Reset (reset=0, asynchronous):
  - State=FETCH; op_q=0; counter=0; Illegal=0; TimeoutErr=0.
  - All other outputs are combinational from state; with State=FETCH they read ImemReq=1 and everything else 0.
- FETCH:
  - ImemReq=1.
  - On imem_ready: IRWrite=1 and PCWrite=1 for that cycle only (Mealy); next state DECODE.
- DECODE (1 cycle):
  - Register Opcode into op_q.
  - Illegal opcode: next TRAP and set Illegal. Otherwise next EXEC.
- EXEC (1 cycle), decoded from op_q:
  - ALUSrc=1 for LW/SW/I/JALR.
  - ALUOp as in the port list.
  - Branch=1 for BR; Jump=1 for JAL/JALR.
  - Next state: BR -> FETCH; LW/SW -> MEM; R/I/JAL/JALR -> WB.
- MEM:
  - MemRead=1 (LW) or MemWrite=1 (SW); the level is held until dmem_ready.
  - On dmem_ready: LW -> WB, SW -> FETCH.
- WB (1 cycle):
  - RegWrite=1; MemtoReg=1 for LW only.
  - Next state FETCH.
- TRAP:
  - All strobes 0; stays in TRAP until reset.
  - Illegal/TimeoutErr hold their values.
- Timeout counter:
  - Clears on entry to FETCH or MEM and increments each wait cycle without ready.
  - When MEM_TIMEOUT>0 and the count reaches MEM_TIMEOUT: next TRAP, set TimeoutErr.
  - If ready arrives in the same cycle the count reaches the limit, ready wins and there is no trap.
- stall=1, in any state:
  - FSM state, op_q and counter all freeze; ready inputs are ignored.
  - IRWrite, PCWrite, RegWrite and MemWrite are forced to 0.
  - ImemReq and MemRead stay asserted so pending requests remain stable.
  - In MEM for an SW: MemWrite is forced to 0 during stall and re-asserts when stall drops.
- Latency with zero-wait memory (ready high on the first request cycle):
  - BR 3 cycles; R/I/SW/JAL/JALR 4 cycles; LW 5 cycles.
- Reset mid-instruction aborts immediately to FETCH. No strobe may glitch high during reset.

Test Plan:
- Reset then R-type, imem_ready=1 -> State 0,1,2,4,0; IRWrite/PCWrite pulse in cycle 0; ALUOp=10 in EXEC; RegWrite=1 only in WB.
- LW with dmem_ready delayed 3 cycles -> MemRead high 4 cycles in MEM, then WB with RegWrite=1, MemtoReg=1; total 8 cycles.
- SW with stall=1 for 2 cycles in MEM -> MemWrite 0 during stall; State holds 3; MemWrite=1 after release; next FETCH with no WB.
- Opcode=1111111 -> DECODE to TRAP; Illegal=1; all strobes 0 for 10 further cycles; reset clears.
- MEM_TIMEOUT=4, imem_ready held 0 -> TRAP after 4 wait cycles, TimeoutErr=1; repeat with ready on the 4th cycle -> no trap.
- ENABLE_JUMPS=0 with JAL -> TRAP and Illegal=1; ENABLE_JUMPS=1 with JAL -> Jump=1, ALUOp=11 in EXEC, then WB with RegWrite=1.
